avmm_mmio_ctrl: RTL and testbench

AVMM_MMIO_CTRL -- requirements
Module: avmm_mmio_ctrl

---
 rtl/afu_csr_pkg.sv | 29 ++
 rtl/avmm_txn_fsm.sv | 94 +++++++++
 rtl/avmm_mmio_ctrl.sv | 138 +++++++++++++
 tb/tb_avmm_mmio_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afu_csr_pkg.sv
// Shared CSR map, STATUS/CMD field positions and transaction FSM states
// for the MMIO-to-Avalon-MM bridge.
package afu_csr_pkg;

  localparam logic [15:0] CSR_OFF_ADDR   = 16'd0;
  localparam logic [15:0] CSR_OFF_WDATA  = 16'd2;
  localparam logic [15:0] CSR_OFF_CMD    = 16'd4;
  localparam logic [15:0] CSR_OFF_STATUS = 16'd6;
  localparam logic [15:0] CSR_OFF_RDATA  = 16'd8;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_TIMEOUT = 2;
  localparam int ST_CMD_ERR = 3;
  localparam int ST_W       = 4;

  localparam int CMD_GO    = 0;
  localparam int CMD_DIR   = 1;
  localparam int CMD_BE_LO = 8;
  localparam int CMD_BE_W  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_REQ  = 2'd1,
    RD_REQ  = 2'd2,
    RD_WAIT = 2'd3
  } txn_state_e;

endpackage

// File: rtl/avmm_txn_fsm.sv
// Avalon-MM transaction engine: FSM, timeout counter, registered master outputs.
// In: cmd_go/dir/be + CSR addr/wdata, slave response. Out: avs_* and status events.
module avmm_txn_fsm
  import afu_csr_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                Clk_400,
  input  logic                SoftReset_n,
  input  logic                cmd_go,
  input  logic                cmd_dir,
  input  logic [CMD_BE_W-1:0] cmd_be,
  input  logic [31:0]         csr_addr,
  input  logic [63:0]         csr_wdata,
  input  logic                avs_waitrequest,
  input  logic                avs_readdatavalid,
  output logic [31:0]         avs_address,
  output logic [63:0]         avs_writedata,
  output logic [7:0]          avs_byteenable,
  output logic                avs_write,
  output logic                avs_read,
  output logic                busy,
  output logic                start,
  output logic                done_set,
  output logic                timeout_set,
  output logic                cmd_err_set,
  output logic                rdata_we
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  txn_state_e    state;
  logic [CW-1:0] cnt;
  logic          wr_ack;
  logic          rd_ack;

  assign busy        = (state != IDLE);
  assign start       = cmd_go && !busy;
  assign cmd_err_set = cmd_go && busy;
  // Timeout wins over a completion landing on the same cycle.
  assign timeout_set = busy && (cnt == LAST);
  assign wr_ack      = (state == WR_REQ) && !avs_waitrequest;
  assign rd_ack      = (state == RD_WAIT) && avs_readdatavalid;
  assign done_set    = !timeout_set && (wr_ack || rd_ack);
  assign rdata_we    = !timeout_set && rd_ack;

  always_ff @(posedge Clk_400) begin
    if (!SoftReset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      avs_address    <= '0;
      avs_writedata  <= '0;
      avs_byteenable <= '0;
      avs_write      <= 1'b0;
      avs_read       <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        state          <= cmd_dir ? RD_REQ : WR_REQ;
        cnt            <= '0;
        avs_address    <= csr_addr;
        avs_writedata  <= csr_wdata;
        avs_byteenable <= cmd_be;
        avs_write      <= !cmd_dir;
        avs_read       <= cmd_dir;
      end
    end else if (timeout_set) begin
      state     <= IDLE;
      avs_write <= 1'b0;
      avs_read  <= 1'b0;
    end else begin
      cnt <= cnt + CW'(1);
      unique case (state)
        WR_REQ: begin
          if (!avs_waitrequest) begin
            state     <= IDLE;
            avs_write <= 1'b0;
          end
        end
        RD_REQ: begin
          if (!avs_waitrequest) begin
            state    <= RD_WAIT;
            avs_read <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (avs_readdatavalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/avmm_mmio_ctrl.sv
// MMIO CSR block that launches single Avalon-MM reads/writes via avmm_txn_fsm.
// In: mmio wr/rd strobes, addr, wdata, tid; Avalon slave resp. Out: mmio_rsp_*, avs_*.
module avmm_mmio_ctrl
  import afu_csr_pkg::*;
#(
  parameter logic [15:0] CSR_BASE    = 16'h0030,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic        Clk_400,
  input  logic        SoftReset_n,
  input  logic        mmio_wr_valid,
  input  logic        mmio_rd_valid,
  input  logic [15:0] mmio_addr,
  input  logic [63:0] mmio_wdata,
  input  logic [8:0]  mmio_tid,
  output logic        mmio_rsp_valid,
  output logic [63:0] mmio_rsp_data,
  output logic [8:0]  mmio_rsp_tid,
  output logic [31:0] avs_address,
  output logic [63:0] avs_writedata,
  output logic [7:0]  avs_byteenable,
  output logic        avs_write,
  output logic        avs_read,
  input  logic [63:0] avs_readdata,
  input  logic        avs_waitrequest,
  input  logic        avs_readdatavalid
);

  localparam logic [15:0] A_ADDR   = CSR_BASE + CSR_OFF_ADDR;
  localparam logic [15:0] A_WDATA  = CSR_BASE + CSR_OFF_WDATA;
  localparam logic [15:0] A_CMD    = CSR_BASE + CSR_OFF_CMD;
  localparam logic [15:0] A_STATUS = CSR_BASE + CSR_OFF_STATUS;
  localparam logic [15:0] A_RDATA  = CSR_BASE + CSR_OFF_RDATA;

  logic [31:0]     addr_q;
  logic [63:0]     wdata_q;
  logic [63:0]     rdata_q;
  logic            done_q;
  logic            tmo_q;
  logic            err_q;
  logic            busy;
  logic            start;
  logic            done_set;
  logic            timeout_set;
  logic            cmd_err_set;
  logic            rdata_we;
  logic            sel_addr;
  logic            sel_wdata;
  logic            sel_cmd;
  logic            sel_status;
  logic            sel_rdata;
  logic            wr_cmd;
  logic            wr_status;
  logic [ST_W-1:0] status;
  logic [ST_W-1:0] clr;
  logic [63:0]     rd_mux;

  assign sel_addr   = (mmio_addr == A_ADDR);
  assign sel_wdata  = (mmio_addr == A_WDATA);
  assign sel_cmd    = (mmio_addr == A_CMD);
  assign sel_status = (mmio_addr == A_STATUS);
  assign sel_rdata  = (mmio_addr == A_RDATA);

  assign wr_cmd    = mmio_wr_valid && sel_cmd;
  assign wr_status = mmio_wr_valid && sel_status;
  assign clr       = wr_status ? mmio_wdata[ST_W-1:0] : '0;

  always_comb begin
    status             = '0;
    status[ST_BUSY]    = busy;
    status[ST_DONE]    = done_q;
    status[ST_TIMEOUT] = tmo_q;
    status[ST_CMD_ERR] = err_q;
  end

  // CMD is write-only, so it falls through to zero with unmapped space.
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_addr:   rd_mux = {32'b0, addr_q};
      sel_wdata:  rd_mux = wdata_q;
      sel_status: rd_mux = {{(64-ST_W){1'b0}}, status};
      sel_rdata:  rd_mux = rdata_q;
      default:    rd_mux = '0;
    endcase
  end

  avmm_txn_fsm #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_fsm (
    .Clk_400          (Clk_400),
    .SoftReset_n      (SoftReset_n),
    .cmd_go           (wr_cmd && mmio_wdata[CMD_GO]),
    .cmd_dir          (mmio_wdata[CMD_DIR]),
    .cmd_be           (mmio_wdata[CMD_BE_LO +: CMD_BE_W]),
    .csr_addr         (addr_q),
    .csr_wdata        (wdata_q),
    .avs_waitrequest  (avs_waitrequest),
    .avs_readdatavalid(avs_readdatavalid),
    .avs_address      (avs_address),
    .avs_writedata    (avs_writedata),
    .avs_byteenable   (avs_byteenable),
    .avs_write        (avs_write),
    .avs_read         (avs_read),
    .busy             (busy),
    .start            (start),
    .done_set         (done_set),
    .timeout_set      (timeout_set),
    .cmd_err_set      (cmd_err_set),
    .rdata_we         (rdata_we)
  );

  always_ff @(posedge Clk_400) begin
    if (!SoftReset_n) begin
      mmio_rsp_valid <= 1'b0;
      mmio_rsp_data  <= '0;
      mmio_rsp_tid   <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      done_q         <= 1'b0;
      tmo_q          <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      mmio_rsp_valid <= mmio_rd_valid;
      mmio_rsp_data  <= mmio_rd_valid ? rd_mux : '0;
      mmio_rsp_tid   <= mmio_rd_valid ? mmio_tid : '0;
      if (mmio_wr_valid && sel_addr && !busy) addr_q <= mmio_wdata[31:0];
      if (mmio_wr_valid && sel_wdata && !busy) wdata_q <= mmio_wdata;
      if (rdata_we) rdata_q <= avs_readdata;
      // Hardware set beats a same-cycle write-1-to-clear.
      done_q <= done_set | (done_q & ~start & ~clr[ST_DONE]);
      tmo_q  <= timeout_set | (tmo_q & ~start & ~clr[ST_TIMEOUT]);
      err_q  <= cmd_err_set | (err_q & ~clr[ST_CMD_ERR]);
    end
  end

endmodule

// File: tb/tb_avmm_mmio_ctrl.sv
// Self-checking bench for avmm_mmio_ctrl: CSR vector table plus
// transaction sequences, MMIO read responses checked through a scoreboard.
module tb_avmm_mmio_ctrl;

  localparam logic [15:0] BASE     = 16'h0030;
  localparam logic [15:0] A_ADDR   = BASE + 16'd0;
  localparam logic [15:0] A_WDATA  = BASE + 16'd2;
  localparam logic [15:0] A_CMD    = BASE + 16'd4;
  localparam logic [15:0] A_STATUS = BASE + 16'd6;
  localparam logic [15:0] A_RDATA  = BASE + 16'd8;

  logic        Clk_400;
  logic        SoftReset_n;
  logic        mmio_wr_valid;
  logic        mmio_rd_valid;
  logic [15:0] mmio_addr;
  logic [63:0] mmio_wdata;
  logic [8:0]  mmio_tid;
  logic        mmio_rsp_valid;
  logic [63:0] mmio_rsp_data;
  logic [8:0]  mmio_rsp_tid;
  logic [31:0] avs_address;
  logic [63:0] avs_writedata;
  logic [7:0]  avs_byteenable;
  logic        avs_write;
  logic        avs_read;
  logic [63:0] avs_readdata;
  logic        avs_waitrequest;
  logic        avs_readdatavalid;

  avmm_mmio_ctrl #(
    .CSR_BASE   (BASE),
    .TIMEOUT_CYC(16)
  ) dut (
    .Clk_400          (Clk_400),
    .SoftReset_n      (SoftReset_n),
    .mmio_wr_valid    (mmio_wr_valid),
    .mmio_rd_valid    (mmio_rd_valid),
    .mmio_addr        (mmio_addr),
    .mmio_wdata       (mmio_wdata),
    .mmio_tid         (mmio_tid),
    .mmio_rsp_valid   (mmio_rsp_valid),
    .mmio_rsp_data    (mmio_rsp_data),
    .mmio_rsp_tid     (mmio_rsp_tid),
    .avs_address      (avs_address),
    .avs_writedata    (avs_writedata),
    .avs_byteenable   (avs_byteenable),
    .avs_write        (avs_write),
    .avs_read         (avs_read),
    .avs_readdata     (avs_readdata),
    .avs_waitrequest  (avs_waitrequest),
    .avs_readdatavalid(avs_readdatavalid)
  );

  initial Clk_400 = 1'b0;
  always #5 Clk_400 = ~Clk_400;

  typedef struct {
    logic [63:0] data;
    logic [8:0]  tid;
    int unsigned due;
  } rsp_t;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [63:0] data;
  } vec_t;

  rsp_t        sb[$];
  vec_t        tv[$];
  int          n_vec;
  int          n_bad;
  int unsigned cyc;

  initial begin
    n_vec = 0;
    n_bad = 0;
    cyc   = 0;
  end

  always @(posedge Clk_400) cyc++;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge Clk_400) begin
    rsp_t e;
    if (mmio_rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL rsp_unexpected: got valid expected none");
      end else begin
        e = sb.pop_front();
        chk("rsp_data", mmio_rsp_data, e.data);
        chk("rsp_tid", 64'(mmio_rsp_tid), 64'(e.tid));
        chk("rsp_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic tick();
    @(posedge Clk_400);
    #1;
  endtask

  task automatic mmio_wr(input logic [15:0] a, input logic [63:0] d);
    mmio_wr_valid = 1'b1;
    mmio_addr     = a;
    mmio_wdata    = d;
    tick();
    mmio_wr_valid = 1'b0;
  endtask

  task automatic mmio_rd(input logic [15:0] a, input logic [63:0] exp,
                         input logic [8:0] tid);
    mmio_rd_valid = 1'b1;
    mmio_addr     = a;
    mmio_tid      = tid;
    sb.push_back('{exp, tid, cyc + 1});
    tick();
    mmio_rd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit ok;
    SoftReset_n       = 1'b0;
    mmio_wr_valid     = 1'b0;
    mmio_rd_valid     = 1'b0;
    mmio_addr         = '0;
    mmio_wdata        = '0;
    mmio_tid          = '0;
    avs_readdata      = '0;
    avs_waitrequest   = 1'b0;
    avs_readdatavalid = 1'b0;
    repeat (3) tick();
    chk("rst_avs_write", 64'(avs_write), 64'd0);
    chk("rst_avs_read", 64'(avs_read), 64'd0);
    chk("rst_avs_address", 64'(avs_address), 64'd0);
    chk("rst_avs_wdata", avs_writedata, 64'd0);
    chk("rst_avs_be", 64'(avs_byteenable), 64'd0);
    chk("rst_rsp_valid", 64'(mmio_rsp_valid), 64'd0);
    SoftReset_n = 1'b1;
    tick();

    // CSR vectors: reads carry the expected value, writes the data.
    tv.push_back('{0, A_ADDR,   64'h0});
    tv.push_back('{0, A_WDATA,  64'h0});
    tv.push_back('{0, A_STATUS, 64'h0});
    tv.push_back('{0, A_RDATA,  64'h0});
    tv.push_back('{1, A_ADDR,   64'hFFFF_FFFF_1234_5678});
    tv.push_back('{0, A_ADDR,   64'h0000_0000_1234_5678});
    tv.push_back('{1, A_WDATA,  64'hA5A5_5A5A_0F0F_F0F0});
    tv.push_back('{0, A_WDATA,  64'hA5A5_5A5A_0F0F_F0F0});
    tv.push_back('{1, A_CMD,    64'h0000_FF02});
    tv.push_back('{0, A_STATUS, 64'h0});
    tv.push_back('{0, A_CMD,    64'h0});
    tv.push_back('{0, BASE + 16'd1,  64'h0});
    tv.push_back('{0, BASE + 16'd10, 64'h0});
    tv.push_back('{0, 16'h0000, 64'h0});
    foreach (tv[i]) begin
      if (tv[i].wr) mmio_wr(tv[i].addr, tv[i].data);
      else mmio_rd(tv[i].addr, tv[i].data, 9'(i * 37));
    end
    chk("go0_no_write", 64'(avs_write), 64'd0);
    chk("go0_no_read", 64'(avs_read), 64'd0);

    // Write with waitrequest held for three cycles.
    mmio_wr(A_ADDR, 64'h100);
    mmio_wr(A_WDATA, 64'hDEADBEEF);
    avs_waitrequest = 1'b1;
    mmio_wr(A_CMD, 64'hFF01);
    n  = 0;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (avs_write !== 1'b1) break;
      ok = ok && avs_address == 32'h100 && avs_writedata == 64'hDEADBEEF &&
           avs_byteenable == 8'hFF && avs_read == 1'b0;
      n++;
      if (n == 4) avs_waitrequest = 1'b0;
      tick();
    end
    avs_waitrequest = 1'b0;
    chk("wr_cycles", 64'(n), 64'd4);
    chk("wr_stable", 64'(ok), 64'd1);
    chk("wr_end", 64'(avs_write), 64'd0);
    mmio_rd(A_STATUS, 64'h2, 9'h011);

    // Clear of done on the very edge that sets it.
    mmio_wr(A_CMD, 64'h0301);
    chk("wr2_write", 64'(avs_write), 64'd1);
    chk("wr2_be", 64'(avs_byteenable), 64'h03);
    mmio_wr(A_STATUS, 64'h2);
    chk("wr2_end", 64'(avs_write), 64'd0);
    mmio_rd(A_STATUS, 64'h2, 9'h012);
    mmio_wr(A_STATUS, 64'h2);
    mmio_rd(A_STATUS, 64'h0, 9'h013);

    // Read, busy status read, ADDR write ignored while busy.
    mmio_wr(A_ADDR, 64'h200);
    mmio_wr(A_CMD, 64'hFF03);
    chk("rd_read", 64'(avs_read), 64'd1);
    chk("rd_addr", 64'(avs_address), 64'h200);
    chk("rd_be", 64'(avs_byteenable), 64'hFF);
    tick();
    chk("rd_read_drop", 64'(avs_read), 64'd0);
    mmio_rd(A_STATUS, 64'h1, 9'h1A5);
    mmio_wr(A_ADDR, 64'h999);
    tick();
    tick();
    avs_readdatavalid = 1'b1;
    avs_readdata      = 64'h1234;
    tick();
    avs_readdatavalid = 1'b0;
    avs_readdata      = '0;
    mmio_rd(A_RDATA, 64'h1234, 9'h021);
    mmio_rd(A_STATUS, 64'h2, 9'h022);
    mmio_rd(A_ADDR, 64'h200, 9'h023);
    avs_readdatavalid = 1'b1;
    avs_readdata      = 64'hBAD;
    tick();
    avs_readdatavalid = 1'b0;
    mmio_rd(A_RDATA, 64'h1234, 9'h024);

    // Second go while waiting for read data.
    mmio_wr(A_STATUS, 64'hF);
    mmio_wr(A_ADDR, 64'h300);
    mmio_wr(A_CMD, 64'h0F03);
    tick();
    mmio_wr(A_CMD, 64'h0F03);
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (avs_read !== 1'b0) ok = 1'b1;
      tick();
    end
    chk("conflict_no_read", 64'(ok), 64'd0);
    mmio_rd(A_STATUS, 64'h9, 9'h031);
    avs_readdatavalid = 1'b1;
    avs_readdata      = 64'h55;
    tick();
    avs_readdatavalid = 1'b0;
    mmio_rd(A_STATUS, 64'hA, 9'h032);
    mmio_wr(A_STATUS, 64'h8);
    mmio_rd(A_STATUS, 64'h2, 9'h033);
    mmio_rd(A_RDATA, 64'h55, 9'h034);

    // Timeout with the slave never accepting.
    mmio_wr(A_STATUS, 64'hF);
    avs_waitrequest = 1'b1;
    mmio_wr(A_ADDR, 64'h400);
    mmio_wr(A_CMD, 64'hFF03);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (avs_read !== 1'b1) break;
      n++;
      tick();
    end
    chk("tmo_cycles", 64'(n), 64'd16);
    tick();
    chk("tmo_read_low", 64'(avs_read), 64'd0);
    avs_waitrequest = 1'b0;
    mmio_rd(A_STATUS, 64'h4, 9'h041);
    mmio_rd(A_RDATA, 64'h55, 9'h042);

    // Reset in the middle of a stalled write.
    mmio_wr(A_STATUS, 64'hF);
    avs_waitrequest = 1'b1;
    mmio_wr(A_WDATA, 64'h77);
    mmio_wr(A_CMD, 64'h0101);
    chk("rstw_write", 64'(avs_write), 64'd1);
    tick();
    SoftReset_n = 1'b0;
    tick();
    chk("rstw_write_low", 64'(avs_write), 64'd0);
    chk("rstw_addr", 64'(avs_address), 64'd0);
    chk("rstw_wdata", avs_writedata, 64'd0);
    chk("rstw_be", 64'(avs_byteenable), 64'd0);
    SoftReset_n     = 1'b1;
    avs_waitrequest = 1'b0;
    tick();
    avs_readdatavalid = 1'b1;
    avs_readdata      = 64'hBEEF;
    tick();
    avs_readdatavalid = 1'b0;
    mmio_rd(A_STATUS, 64'h0, 9'h051);
    mmio_rd(A_RDATA, 64'h0, 9'h052);
    mmio_rd(A_WDATA, 64'h0, 9'h053);
    mmio_rd(A_ADDR, 64'h0, 9'h054);
    tick();
    tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
